// File: rtl/sync_fifo_pro.sv
// Synchronous FIFO with an occupancy counter, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a selectable first-word-fall-through read port.
module sync_fifo_pro #(
    parameter int DEEPWID = 3,
    parameter int BITWID  = 5,
    parameter bit FWFT    = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [BITWID-1:0]  wr_data,
    input  logic               rd_en,
    input  logic [DEEPWID-1:0] cfg_almost_full,
    input  logic [DEEPWID-1:0] cfg_almost_empty,
    input  logic               err_clr,
    output logic [BITWID-1:0]  rd_data,
    output logic               rd_data_vld,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [DEEPWID:0]   fifo_num,
    output logic               overflow,
    output logic               underflow
);

    localparam int               DEPTH   = 2 ** DEEPWID;
    localparam logic [DEEPWID:0] DEPTH_C = (DEEPWID + 1)'(DEPTH);
    localparam logic [DEEPWID:0] CNT_0   = {(DEEPWID + 1){1'b0}};
    localparam logic [DEEPWID:0] CNT_1   = {{DEEPWID{1'b0}}, 1'b1};
    localparam logic [DEEPWID-1:0] PTR_0 = {DEEPWID{1'b0}};
    localparam logic [DEEPWID-1:0] PTR_1 = {{(DEEPWID - 1){1'b0}}, 1'b1};

    logic [BITWID-1:0]  mem_q [DEPTH];
    logic [DEEPWID-1:0] wptr_q, wptr_d;
    logic [DEEPWID-1:0] rptr_q, rptr_d;
    logic [DEEPWID:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;
    logic               wr_acc_s;
    logic               rd_acc_s;

    // Acceptance uses the flags decoded from the pre-edge count
    assign full     = (cnt_q == DEPTH_C);
    assign empty    = (cnt_q == CNT_0);
    assign wr_acc_s = wr_en & ~full;
    assign rd_acc_s = rd_en & ~empty;

    assign almost_full  = (cnt_q >= (DEPTH_C - {1'b0, cfg_almost_full}));
    assign almost_empty = (cnt_q <= {1'b0, cfg_almost_empty});
    assign fifo_num     = cnt_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // Next-state for pointers, occupancy and sticky error flags
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        udf_d  = udf_q;
        if (wr_acc_s) begin
            wptr_d = wptr_q + PTR_1;
        end else begin
            wptr_d = wptr_q;
        end
        if (rd_acc_s) begin
            rptr_d = rptr_q + PTR_1;
        end else begin
            rptr_d = rptr_q;
        end
        case ({wr_acc_s, rd_acc_s})
            2'b10:   cnt_d = cnt_q + CNT_1;
            2'b01:   cnt_d = cnt_q - CNT_1;
            default: cnt_d = cnt_q;
        endcase
        // A new error event outranks a clear issued in the same cycle
        if (wr_en && full) begin
            ovf_d = 1'b1;
        end else if (err_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (rd_en && empty) begin
            udf_d = 1'b1;
        end else if (err_clr) begin
            udf_d = 1'b0;
        end else begin
            udf_d = udf_q;
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= PTR_0;
            rptr_q <= PTR_0;
            cnt_q  <= CNT_0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_acc_s && !rst) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign rd_data     = mem_q[rptr_q];
            assign rd_data_vld = ~empty;
        end else begin : g_std
            logic [BITWID-1:0] rd_data_q;
            logic              rd_vld_q;

            // Registered read port: one-cycle valid pulse, data held between reads
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q <= {BITWID{1'b0}};
                    rd_vld_q  <= 1'b0;
                end else begin
                    rd_vld_q <= rd_acc_s;
                    if (rd_acc_s) begin
                        rd_data_q <= mem_q[rptr_q];
                    end
                end
            end

            assign rd_data     = rd_data_q;
            assign rd_data_vld = rd_vld_q;
        end
    endgenerate

endmodule
